// File: rtl/edge_event_counter.sv
// Counts rising and falling edges of an asynchronous level within a snapshot window
// and presents each window's totals over a Valid/Rdy handshake.
module edge_event_counter #(
    parameter int CW = 8
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          Din,
    input  logic          Snap,
    input  logic          Rdy,
    output logic          Valid,
    output logic [CW-1:0] RiseCnt,
    output logic [CW-1:0] FallCnt,
    output logic          Ovf,
    output logic          Level
);
    // state | meaning
    // IDLE  | counting edges, waiting for a Snap request
    // HOLD  | snapshot presented (Valid=1), waiting for Rdy; counting continues
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          r_s1;
    logic          r_s2;
    logic          r_p;
    logic [CW-1:0] r_rc;
    logic [CW-1:0] r_fc;
    logic          r_ro;
    logic [0:0]    r_state;
    logic [CW-1:0] r_rise_cnt;
    logic [CW-1:0] r_fall_cnt;
    logic          r_ovf;

    logic          w_rise;
    logic          w_fall;
    logic          w_rc_sat;
    logic          w_fc_sat;
    logic [CW-1:0] w_rc_inc;
    logic [CW-1:0] w_fc_inc;
    logic          w_ovf_hit;
    logic          w_capture;
    logic          w_release;

    assign w_rise    = r_s2 & ~r_p;
    assign w_fall    = ~r_s2 & r_p;
    assign w_rc_sat  = (r_rc == CNT_MAX);
    assign w_fc_sat  = (r_fc == CNT_MAX);
    assign w_rc_inc  = w_rc_sat ? r_rc : r_rc + {{(CW-1){1'b0}}, 1'b1};
    assign w_fc_inc  = w_fc_sat ? r_fc : r_fc + {{(CW-1){1'b0}}, 1'b1};
    assign w_ovf_hit = (w_rise & w_rc_sat) | (w_fall & w_fc_sat);
    assign w_capture = (r_state == IDLE) & Snap;
    assign w_release = (r_state == HOLD) & Rdy;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_p  <= 1'b0;
        end else begin
            r_s1 <= Din;
            r_s2 <= r_s1;
            r_p  <= r_s2;
        end
    end

    // A capture restarts the window, but a detect on the same edge belongs to the new window.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_rc <= '0;
            r_fc <= '0;
            r_ro <= 1'b0;
        end else if (w_capture) begin
            r_rc <= {{(CW-1){1'b0}}, w_rise};
            r_fc <= {{(CW-1){1'b0}}, w_fall};
            r_ro <= 1'b0;
        end else begin
            if (w_rise) begin
                r_rc <= w_rc_inc;
            end
            if (w_fall) begin
                r_fc <= w_fc_inc;
            end
            if (w_ovf_hit) begin
                r_ro <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state    <= IDLE;
            r_rise_cnt <= '0;
            r_fall_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_rise_cnt <= r_rc;
                        r_fall_cnt <= r_fc;
                        r_ovf      <= r_ro;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_release) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Valid   = (r_state == HOLD);
    assign RiseCnt = r_rise_cnt;
    assign FallCnt = r_fall_cnt;
    assign Ovf     = r_ovf;
    assign Level   = r_s2;

endmodule

// File: tb/tb_edge_event_counter.sv
// Scoreboard bench for edge_event_counter: an 8-bit and a 2-bit instance share stimulus
// and are checked against an unbounded-count window model.
module tb_edge_event_counter;
    localparam int MAX8 = 255;
    localparam int MAX2 = 3;

    logic       Clk = 1'b0;
    logic       Clr;
    logic       Din;
    logic       Snap;
    logic       Rdy;
    logic       v0, v1, l0, l1, o0, o1;
    logic [7:0] r0, f0;
    logic [1:0] r1, f1;

    int errors = 0;
    int checks = 0;

    edge_event_counter #(.CW(8)) u_dut8 (
        .Clk(Clk), .Clr(Clr), .Din(Din), .Snap(Snap), .Rdy(Rdy),
        .Valid(v0), .RiseCnt(r0), .FallCnt(f0), .Ovf(o0), .Level(l0)
    );

    edge_event_counter #(.CW(2)) u_dut2 (
        .Clk(Clk), .Clr(Clr), .Din(Din), .Snap(Snap), .Rdy(Rdy),
        .Valid(v1), .RiseCnt(r1), .FallCnt(f1), .Ovf(o1), .Level(l1)
    );

    always #50 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: Din as sampled at each rising edge; an edge is counted two
    // samples after it appears, window counts are unbounded and clipped on compare.
    typedef struct {
        int rise;
        int fall;
    } snap_t;

    snap_t q[$];
    bit    hist [0:2] = '{1'b0, 1'b0, 1'b0};
    int    m_rise = 0;
    int    m_fall = 0;
    bit    m_hold = 1'b0;
    bit    clr_evt = 1'b0;
    bit    m_r, m_f;

    always @(posedge Clk) begin
        m_r = hist[1] && !hist[0];
        m_f = !hist[1] && hist[0];
        if (Clr) begin
            hist    = '{1'b0, 1'b0, 1'b0};
            m_rise  = 0;
            m_fall  = 0;
            m_hold  = 1'b0;
            clr_evt = 1'b1;
            q.delete();
        end else begin
            if (!m_hold && Snap) begin
                q.push_back('{rise: m_rise, fall: m_fall});
                m_rise = int'(m_r);
                m_fall = int'(m_f);
                m_hold = 1'b1;
            end else begin
                m_rise += int'(m_r);
                m_fall += int'(m_f);
                if (m_hold && Rdy) m_hold = 1'b0;
            end
            hist = '{hist[1], hist[2], Din};
        end
    end

    // Monitor: pops a snapshot when Valid appears, then checks outputs every cycle.
    int    exp_r = 0;
    int    exp_f = 0;
    bit    prev_v = 1'b0;
    snap_t s;

    always @(negedge Clk) begin
        if (clr_evt) begin
            exp_r   = 0;
            exp_f   = 0;
            clr_evt = 1'b0;
        end
        if (v0 === 1'b1 && !prev_v) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_valid", 1, 0);
            end else begin
                s     = q.pop_front();
                exp_r = s.rise;
                exp_f = s.fall;
            end
        end
        prev_v = (v0 === 1'b1);
        chk("valid8", v0, int'(m_hold));
        chk("valid2", v1, int'(m_hold));
        chk("level8", l0, int'(hist[1]));
        chk("level2", l1, int'(hist[1]));
        chk("rise8", r0, clip(exp_r, MAX8));
        chk("fall8", f0, clip(exp_f, MAX8));
        chk("ovf8", o0, int'(exp_r > MAX8 || exp_f > MAX8));
        chk("rise2", r1, clip(exp_r, MAX2));
        chk("fall2", f1, clip(exp_f, MAX2));
        chk("ovf2", o1, int'(exp_r > MAX2 || exp_f > MAX2));
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic do_snap();
        Snap = 1'b1;
        tick();
        Snap = 1'b0;
        for (int i = 0; i < 4 && v0 !== 1'b1; i++) tick();
        chk("snap_valid", v0, 1);
    endtask

    task automatic release_snap();
        Rdy = 1'b1;
        tick();
        Rdy = 1'b0;
        chk("valid_drop", v0, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Clr  = 1'b1;
        Din  = 1'b1;
        Snap = 1'b0;
        Rdy  = 1'b0;
        tick();
        tick();
        chk("rst_valid", v0, 0);
        chk("rst_rise", r0, 0);
        chk("rst_fall", f0, 0);
        chk("rst_ovf", o0, 0);
        chk("rst_level", l0, 0);
        chk("rst_rise2", r1, 0);

        // Din already high at release: one rising edge is seen after the synchronizer fills.
        Clr = 1'b0;
        tick();
        chk("rel_level_1edge", l0, 0);
        tick();
        chk("rel_level_2edge", l0, 1);
        tick();
        tick();
        do_snap();
        chk("rel_rise", r0, 1);
        chk("rel_fall", f0, 0);
        release_snap();

        // Fast toggling (70 ns vs 100 ns clock): counts follow the sampled levels.
        Din = 1'b0;
        repeat (4) tick();
        do_snap();
        release_snap();
        #5;
        repeat (8) begin
            Din = ~Din;
            #70;
        end
        tick();
        repeat (4) tick();
        do_snap();
        release_snap();

        // Eight slow transitions from settled low: four of each edge.
        repeat (8) begin
            Din = ~Din;
            repeat (3) tick();
        end
        repeat (2) tick();
        do_snap();
        chk("slow_rise8", r0, 4);
        chk("slow_fall8", f0, 4);
        chk("slow_ovf8", o0, 0);
        chk("slow_rise2", r1, 3);
        chk("slow_ovf2", o1, 1);
        release_snap();

        // Five rising edges saturate the 2-bit counter; an empty window clears Ovf.
        repeat (5) begin
            Din = 1'b1;
            repeat (3) tick();
            Din = 1'b0;
            repeat (3) tick();
        end
        do_snap();
        chk("sat_rise2", r1, 3);
        chk("sat_ovf2", o1, 1);
        chk("sat_rise8", r0, 5);
        chk("sat_ovf8", o0, 0);
        release_snap();
        repeat (2) tick();
        do_snap();
        chk("empty_rise2", r1, 0);
        chk("empty_ovf2", o1, 0);
        release_snap();

        // Held snapshot while Din keeps toggling; later window carries the edges.
        do_snap();
        repeat (10) begin
            Din = ~Din;
            tick();
            tick();
        end
        chk("hold_valid", v0, 1);
        release_snap();
        Din = 1'b0;
        repeat (4) tick();
        do_snap();
        release_snap();

        // Detect on the same edge as the capture goes into the new window.
        repeat (3) tick();
        do_snap();
        release_snap();
        Din = 1'b1;
        tick();
        tick();
        do_snap();
        chk("same_edge_cap", r0, 0);
        release_snap();
        repeat (2) tick();
        do_snap();
        chk("same_edge_next", r0, 1);
        release_snap();

        // Clear during HOLD discards the pending snapshot.
        do_snap();
        tick();
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        chk("clr_hold_valid", v0, 0);
        chk("clr_hold_rise", r0, 0);
        chk("clr_hold_fall", f0, 0);
        chk("clr_hold_level", l0, 0);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 2) == 0) Din = ~Din;
            Snap = ($urandom_range(0, 3) == 0);
            Rdy  = ($urandom_range(0, 1) == 0);
            Clr  = ($urandom_range(0, 59) == 0);
            tick();
        end

        Clr  = 1'b0;
        Snap = 1'b0;
        Rdy  = 1'b1;
        repeat (4) tick();
        chk("sb_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
